// File: rtl/display_scan_ctrl.sv
// Multiplexed 4-digit 7-segment scan controller: slot/digit counters, per-slot blanking,
// leading-zero suppression and frame-synchronous update of the displayed value.
module display_scan_ctrl #(
  parameter int unsigned SCAN_DIV       = 50000,
  parameter int unsigned BLANK_CYC      = 500,
  parameter int unsigned DIGIT_POLARITY = 1
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        Load,
  input  logic [15:0] Value,
  input  logic [3:0]  DpMask,
  input  logic        LzbEn,
  output logic [3:0]  NbOut,
  output logic        Blank,
  output logic        Dp,
  output logic [3:0]  DigitEn,
  output logic        Busy,
  output logic        Ack,
  output logic        FrameTick
);

  localparam int unsigned    CW         = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0]  SLOT_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0]  SHOW_FIRST = CW'(BLANK_CYC);
  localparam logic [3:0]     DIG_OFF    = (DIGIT_POLARITY != 0) ? 4'b0000 : 4'b1111;

  typedef enum logic {
    PH_BLANK,
    PH_SHOW
  } phase_t;

  logic [CW-1:0] slotCnt, slotNext;
  logic [1:0]    idx, idxNext;
  logic          started;
  logic [15:0]   dispVal, pendVal;
  logic [3:0]    dispDp, pendDp;

  phase_t        phaseNext;
  logic          tickNext;
  logic          leadZero;
  logic [3:0]    digOn;
  logic [3:0]    digEnD;
  logic [3:0]    nbD;
  logic          blankD;
  logic          dpD;

  // The first edge after reset only arms the counters, so slot 0 starts at SlotCnt=0.
  always_comb begin
    slotNext = slotCnt;
    idxNext  = idx;
    if (started) begin
      if (slotCnt == SLOT_LAST) begin
        slotNext = '0;
        idxNext  = idx + 2'd1;
      end else begin
        slotNext = slotCnt + CW'(1);
      end
    end
    phaseNext = (slotNext < SHOW_FIRST) ? PH_BLANK : PH_SHOW;
    tickNext  = (idxNext == 2'd3) && (slotNext == SLOT_LAST);
  end

  // Outputs are decoded from the next counter values and the currently displayed
  // value, so the last cycle of a frame still shows the old value.
  always_comb begin
    leadZero = 1'b0;
    case (idxNext)
      2'd1:    leadZero = (dispVal[15:4] == '0);
      2'd2:    leadZero = (dispVal[15:8] == '0);
      2'd3:    leadZero = (dispVal[15:12] == '0);
      default: leadZero = 1'b0;
    endcase

    digOn  = 4'b0001 << idxNext;
    digEnD = DIG_OFF;
    nbD    = '0;
    blankD = 1'b1;
    dpD    = 1'b0;
    case (phaseNext)
      PH_SHOW: begin
        digEnD = (DIGIT_POLARITY != 0) ? digOn : ~digOn;
        nbD    = dispVal[{idxNext, 2'b00} +: 4];
        blankD = LzbEn & leadZero;
        dpD    = dispDp[idxNext];
      end
      default: begin
        digEnD = DIG_OFF;
        nbD    = '0;
        blankD = 1'b1;
        dpD    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      started   <= 1'b0;
      slotCnt   <= '0;
      idx       <= '0;
      dispVal   <= '0;
      dispDp    <= '0;
      pendVal   <= '0;
      pendDp    <= '0;
      Busy      <= 1'b0;
      Ack       <= 1'b0;
      FrameTick <= 1'b0;
      NbOut     <= '0;
      Blank     <= 1'b1;
      Dp        <= 1'b0;
      DigitEn   <= DIG_OFF;
    end else begin
      started   <= 1'b1;
      slotCnt   <= slotNext;
      idx       <= idxNext;
      FrameTick <= tickNext;
      NbOut     <= nbD;
      Blank     <= blankD;
      Dp        <= dpD;
      DigitEn   <= digEnD;
      Ack       <= 1'b0;

      if (Load) begin
        pendVal <= Value;
        pendDp  <= DpMask;
        Busy    <= 1'b1;
      end

      // A Load coinciding with the frame tick bypasses the pending register.
      if (tickNext && (Busy || Load)) begin
        dispVal <= Load ? Value : pendVal;
        dispDp  <= Load ? DpMask : pendDp;
        Busy    <= 1'b0;
        Ack     <= 1'b1;
      end
    end
  end

endmodule

// File: doc/display_scan_ctrl.md
DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, clock cycles per digit slot (>=2).
REQ-002 SHALL have parameter BLANK_CYC, default 500, blanking cycles at the start of each slot (1 <= BLANK_CYC < SCAN_DIV).
REQ-003 SHALL have parameter DIGIT_POLARITY, default 1, active level of DigitEn (1 = active-high, 0 = active-low).
REQ-004 SHALL have port Clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL have port Rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port Load  input  1  request to capture Value/DpMask.
REQ-007 SHALL have port Value  input  16  four BCD/hex nibbles; [3:0] is digit 0, [15:12] is digit 3.
REQ-008 SHALL have port DpMask  input  4  decimal-point request per digit.
REQ-009 SHALL have port LzbEn  input  1  leading-zero blanking enable, sampled every cycle.
REQ-010 SHALL have port NbOut  output  4  nibble for the shared 7-segment decoder.
REQ-011 SHALL have port Blank  output  1  1 = decoder segments must be forced off.
REQ-012 SHALL have port Dp  output  1  decimal point for the active digit, active-high.
REQ-013 SHALL have port DigitEn  output  4  one-hot digit enable, polarity per DIGIT_POLARITY.
REQ-014 SHALL have port Busy  output  1  a captured value is pending display.
REQ-015 SHALL have port Ack  output  1  one-cycle pulse when pending value becomes displayed.
REQ-016 SHALL have port FrameTick  output  1  one-cycle pulse on the last cycle of each 4-digit frame.

Function
REQ-017 SHALL maintain SlotCnt (0..SCAN_DIV-1) and 2-bit digit index Idx; SlotCnt increments every cycle, wraps to 0 after SCAN_DIV-1, and Idx increments mod 4 on that wrap.
REQ-018 SHALL implement states BLANK (SlotCnt < BLANK_CYC) and SHOW (SlotCnt >= BLANK_CYC); in BLANK all DigitEn inactive, Blank=1, Dp=0.
REQ-019 SHALL, in SHOW, drive DigitEn[Idx] active and others inactive, NbOut = displayed nibble Idx, Dp = displayed DpMask[Idx].
REQ-020 SHALL register all outputs; DigitEn/NbOut/Blank/Dp reflect the SlotCnt/Idx of the same cycle (counters and outputs updated on the same edge).
REQ-021 SHALL, when LzbEn=1 in SHOW, assert Blank for digit i (i=1..3) if nibbles i..3 of the displayed value are all zero; digit 0 never leading-zero blanked; DigitEn and Dp unaffected.
REQ-022 SHALL, with LzbEn=0 in SHOW, hold Blank=0.
REQ-023 SHALL capture Value/DpMask into a pending register and set Busy on any cycle with Load=1; Load while Busy overwrites pending (last wins).
REQ-024 SHALL pulse FrameTick on the cycle where Idx=3 and SlotCnt=SCAN_DIV-1.
REQ-025 SHALL, on the FrameTick cycle with Busy=1, transfer pending to displayed, clear Busy, pulse Ack the same cycle; new value shown from digit 0 of the next frame.
REQ-026 SHALL, when Load=1 on the FrameTick cycle, transfer that cycle's Value/DpMask directly to displayed, pulse Ack, and leave Busy=0.
REQ-027 SHALL never change displayed value mid-frame.

Reset
REQ-028 SHALL, while Rst_n=0, force SlotCnt=0, Idx=0, displayed=0, pending=0, Busy=0, Ack=0, FrameTick=0, NbOut=0, Blank=1, Dp=0, DigitEn all inactive.
REQ-029 SHALL, after Rst_n deasserts, start digit 0 slot at SlotCnt=0 on the first active edge; reset mid-frame discards pending and displayed values.

Verification (SCAN_DIV=8, BLANK_CYC=2, DIGIT_POLARITY=1)
REQ-030 SHALL cover: release reset, no Load -> DigitEn cycles 0001,0010,0100,1000 each active 6 of 8 cycles, NbOut=0, FrameTick every 32 cycles.
REQ-031 SHALL cover: Load with Value=16'h1234, DpMask=4'b0010 mid-frame -> Busy=1 until next FrameTick, Ack coincident with it; next frame shows 4,3,2,1 on digits 0..3, Dp=1 only on digit 1.
REQ-032 SHALL cover: Value=16'h0070 displayed, LzbEn=1 -> digits 3,2 Blank=1, digits 1,0 Blank=0 showing 7,0; LzbEn=0 -> no digit blanked.
REQ-033 SHALL cover: two Loads (16'hAAAA then 16'h5555) in one frame -> only 16'h5555 displayed, one Ack.
REQ-034 SHALL cover: Load 16'h9999 exactly on FrameTick cycle -> Ack that cycle, Busy stays 0, 9 shown from next digit 0.
REQ-035 SHALL cover: Rst_n pulsed low mid-SHOW with Busy=1 -> all outputs to REQ-028 values asynchronously; Busy=0, display 0 after release.
